// File: rtl/hist2d_stream.sv
// hist2d_stream: 2D I/Q histogram of saturating counters with batch dump or stream accumulation
module hist2d_stream #(
  parameter int DATA_W  = 32,
  parameter int BIN_AW  = 4,
  parameter int COUNT_W = 16
) (
  input  logic                      clk100,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      data_in,
  input  logic signed [DATA_W-1:0]  i_val,
  input  logic signed [DATA_W-1:0]  q_val,
  input  logic [BIN_AW:0]           i_bin_num,
  input  logic [BIN_AW:0]           q_bin_num,
  input  logic [4:0]                i_bin_shift,
  input  logic [4:0]                q_bin_shift,
  input  logic signed [DATA_W-1:0]  i_min,
  input  logic signed [DATA_W-1:0]  q_min,
  input  logic [15:0]               num_data_pts,
  input  logic                      stream_mode,
  output logic                      ready,
  output logic                      i_q_found,
  output logic                      bin_found,
  output logic [BIN_AW-1:0]         i_bin_coord,
  output logic [BIN_AW-1:0]         q_bin_coord,
  output logic [COUNT_W-1:0]        bin_val,
  output logic [15:0]               oor_count,
  output logic                      dump_valid,
  input  logic                      dump_ready,
  output logic [BIN_AW-1:0]         dump_i,
  output logic [BIN_AW-1:0]         dump_q,
  output logic [COUNT_W-1:0]        dump_count,
  output logic                      dump_last,
  output logic                      done
);
  localparam int AW = 2 * BIN_AW;
  localparam int OW = DATA_W + 1;
  typedef enum logic [2:0] {CLEAR, IDLE, ACCUM, DUMP, DONE} state_t;
  state_t state, state_nxt;
  logic [COUNT_W-1:0] mem [2**AW];
  logic [AW-1:0] clr_addr, addr_r, addr_w;
  logic clr_start, stream_r, in_rng_r, in_rng_w, accept, cls, dump_fire, last_i, last_q;
  logic signed [DATA_W-1:0] i_min_r, q_min_r;
  logic [4:0] i_sh_r, q_sh_r;
  logic [BIN_AW:0] i_num_r, q_num_r;
  logic [15:0] npts_r, smp_cnt;
  logic [1:0] ph;
  logic signed [OW-1:0] i_off, q_off, i_bin_w, q_bin_w;
  logic [COUNT_W-1:0] rd_r, inc_w;
  logic [BIN_AW-1:0] di, dq;
  assign i_bin_w = i_off >>> i_sh_r;
  assign q_bin_w = q_off >>> q_sh_r;
  assign in_rng_w = !i_off[OW-1] && !q_off[OW-1] &&
                    ($unsigned(i_bin_w) < OW'(i_num_r)) && ($unsigned(q_bin_w) < OW'(q_num_r));
  assign addr_w = {i_bin_w[BIN_AW-1:0], q_bin_w[BIN_AW-1:0]};
  assign inc_w = &rd_r ? rd_r : rd_r + 1'b1;
  assign ready = (state == ACCUM) && (ph == 2'd0);
  assign accept = data_in && ready;
  assign cls = ph == 2'd2;
  assign last_i = di == BIN_AW'(i_num_r - 1'b1);
  assign last_q = dq == BIN_AW'(q_num_r - 1'b1);
  assign dump_valid = state == DUMP;
  assign dump_fire = dump_valid && dump_ready;
  assign dump_i = di;
  assign dump_q = dq;
  assign dump_count = dump_valid ? mem[{di, dq}] : '0;
  assign dump_last = dump_valid && last_i && last_q;
  assign done = state == DONE;
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   state_nxt = &clr_addr ? (clr_start ? ACCUM : IDLE) : CLEAR;
      IDLE:    state_nxt = start ? CLEAR : IDLE;
      ACCUM:   state_nxt = (cls && !stream_r && smp_cnt == npts_r) ? DUMP : ACCUM;
      DUMP:    state_nxt = (dump_fire && last_i && last_q) ? DONE : DUMP;
      DONE:    state_nxt = start ? CLEAR : DONE;
      default: state_nxt = CLEAR;
    endcase
  end
  always_ff @(posedge clk100)
    if (state == CLEAR) mem[clr_addr] <= '0;
    else if (cls && in_rng_r) mem[addr_r] <= inc_w;
  always_ff @(posedge clk100) begin
    if (rst) begin
      state <= CLEAR;
      clr_addr <= '0;
      clr_start <= 1'b0;
      i_min_r <= '0;
      q_min_r <= '0;
      i_sh_r <= '0;
      q_sh_r <= '0;
      i_num_r <= '0;
      q_num_r <= '0;
      npts_r <= '0;
      stream_r <= 1'b0;
      ph <= '0;
      i_off <= '0;
      q_off <= '0;
      smp_cnt <= '0;
      in_rng_r <= 1'b0;
      addr_r <= '0;
      rd_r <= '0;
      i_q_found <= 1'b0;
      bin_found <= 1'b0;
      i_bin_coord <= '0;
      q_bin_coord <= '0;
      bin_val <= '0;
      oor_count <= '0;
      di <= '0;
      dq <= '0;
    end else begin
      state <= state_nxt;
      clr_addr <= (state == CLEAR) ? clr_addr + 1'b1 : '0;
      if ((state == IDLE || state == DONE) && start) begin
        clr_start <= 1'b1;
        i_min_r <= i_min;
        q_min_r <= q_min;
        i_sh_r <= i_bin_shift;
        q_sh_r <= q_bin_shift;
        i_num_r <= i_bin_num;
        q_num_r <= q_bin_num;
        npts_r <= num_data_pts;
        stream_r <= stream_mode;
        oor_count <= '0;
        smp_cnt <= '0;
        di <= '0;
        dq <= '0;
      end
      ph <= (accept || ph != 2'd0) ? ph + 2'd1 : 2'd0;
      if (accept) begin
        i_off <= {i_val[DATA_W-1], i_val} - {i_min_r[DATA_W-1], i_min_r};
        q_off <= {q_val[DATA_W-1], q_val} - {q_min_r[DATA_W-1], q_min_r};
        smp_cnt <= smp_cnt + 1'b1;
      end
      if (ph == 2'd1) begin
        in_rng_r <= in_rng_w;
        addr_r <= addr_w;
        rd_r <= mem[addr_w];
      end
      i_q_found <= cls;
      if (cls) begin
        bin_found <= in_rng_r;
        i_bin_coord <= in_rng_r ? addr_r[AW-1:BIN_AW] : '0;
        q_bin_coord <= in_rng_r ? addr_r[BIN_AW-1:0] : '0;
        bin_val <= in_rng_r ? inc_w : '0;
        if (!in_rng_r && oor_count != 16'hFFFF) oor_count <= oor_count + 1'b1;
      end
      if (dump_fire) begin
        dq <= last_q ? '0 : dq + 1'b1;
        di <= last_q ? di + 1'b1 : di;
      end
    end
  end
endmodule

// File: tb/tb_hist2d_stream.sv
// tb_hist2d_stream: table-driven and randomized checks of hist2d_stream against a behavioural model
module tb_hist2d_stream;
  localparam int DW = 32, BA = 4, CW = 2, CMAX = 3;
  logic clk100 = 0, rst = 1, start = 0, data_in = 0, stream_mode = 0, dump_ready = 0;
  logic signed [DW-1:0] i_val = 0, q_val = 0, i_min = 0, q_min = 0;
  logic [BA:0] i_bin_num = 0, q_bin_num = 0;
  logic [4:0] i_bin_shift = 0, q_bin_shift = 0;
  logic [15:0] num_data_pts = 0;
  logic ready, i_q_found, bin_found, dump_valid, dump_last, done;
  logic [BA-1:0] i_bin_coord, q_bin_coord, dump_i, dump_q;
  logic [CW-1:0] bin_val, dump_count;
  logic [15:0] oor_count;
  hist2d_stream #(.DATA_W(DW), .BIN_AW(BA), .COUNT_W(CW)) dut (
    .clk100(clk100), .rst(rst), .start(start), .data_in(data_in),
    .i_val(i_val), .q_val(q_val), .i_bin_num(i_bin_num), .q_bin_num(q_bin_num),
    .i_bin_shift(i_bin_shift), .q_bin_shift(q_bin_shift), .i_min(i_min), .q_min(q_min),
    .num_data_pts(num_data_pts), .stream_mode(stream_mode), .ready(ready),
    .i_q_found(i_q_found), .bin_found(bin_found), .i_bin_coord(i_bin_coord),
    .q_bin_coord(q_bin_coord), .bin_val(bin_val), .oor_count(oor_count),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_i(dump_i), .dump_q(dump_q),
    .dump_count(dump_count), .dump_last(dump_last), .done(done)
  );
  always #5 clk100 = ~clk100;
  typedef struct { int iv; int qv; bit f; int ci; int cq; int bv; int oo; } vec_t;
  vec_t tv[17];
  int ntot = 0, npass = 0;
  int cf_imin, cf_qmin, cf_ish, cf_qsh, cf_inum, cf_qnum, cf_npts;
  bit cf_stream;
  int tbl[16][16];
  int oor_m;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask
  task automatic mdl_clear;
    foreach (tbl[a, b]) tbl[a][b] = 0;
    oor_m = 0;
  endtask
  task automatic mdl(input int iv, input int qv, output bit f, output int ci, output int cq, output int bv);
    longint oi, oq, bi, bq;
    oi = longint'(iv) - longint'(cf_imin);
    oq = longint'(qv) - longint'(cf_qmin);
    bi = oi >= 0 ? oi / (longint'(1) << cf_ish) : -1;
    bq = oq >= 0 ? oq / (longint'(1) << cf_qsh) : -1;
    f = oi >= 0 && oq >= 0 && bi < cf_inum && bq < cf_qnum;
    ci = 0; cq = 0; bv = 0;
    if (f) begin
      ci = int'(bi); cq = int'(bq);
      if (tbl[ci][cq] < CMAX) tbl[ci][cq]++;
      bv = tbl[ci][cq];
    end else if (oor_m < 65535) oor_m++;
  endtask
  task automatic send(input int iv, input int qv, input bit ef, input int eci, input int ecq,
                      input int ebv, input int eoo);
    int n = 0;
    while (!ready && n < 20) begin @(negedge clk100); n++; end
    chk("ready", ready, 1);
    data_in = 1; i_val = iv; q_val = qv;
    @(negedge clk100);
    data_in = 0; i_val = $urandom; q_val = $urandom;
    chk("busy_after_accept", ready, 0);
    n = 1;
    while (!i_q_found && n < 8) begin @(negedge clk100); n++; end
    chk("found_latency", n, 3);
    chk("result", {bin_found, i_bin_coord, q_bin_coord, bin_val, oor_count},
        {ef, 4'(eci), 4'(ecq), 2'(ebv), 16'(eoo)});
    @(negedge clk100);
    chk("found_pulse", i_q_found, 0);
  endtask
  task automatic msend(input int iv, input int qv);
    bit f; int ci, cq, bv;
    mdl(iv, qv, f, ci, cq, bv);
    send(iv, qv, f, ci, cq, bv, oor_m);
  endtask
  task automatic run_vec(input int lo, input int hi);
    bit f; int ci, cq, bv;
    for (int k = lo; k <= hi; k++) begin
      mdl(tv[k].iv, tv[k].qv, f, ci, cq, bv);
      send(tv[k].iv, tv[k].qv, tv[k].f, tv[k].ci, tv[k].cq, tv[k].bv, tv[k].oo);
    end
  endtask
  task automatic do_reset;
    bit hi = 0;
    rst = 1; data_in = 0; start = 0; dump_ready = 0;
    @(negedge clk100); @(negedge clk100);
    chk("reset_outputs", {ready, i_q_found, bin_found, i_bin_coord, q_bin_coord, bin_val, oor_count,
        dump_valid, dump_i, dump_q, dump_count, dump_last, done}, 0);
    rst = 0;
    repeat (300) begin @(negedge clk100); if (ready) hi = 1; end
    chk("ready_low_after_reset", hi, 0);
    mdl_clear;
  endtask
  task automatic do_start;
    int n = 1;
    mdl_clear;
    i_min = cf_imin; q_min = cf_qmin; i_bin_shift = 5'(cf_ish); q_bin_shift = 5'(cf_qsh);
    i_bin_num = 5'(cf_inum); q_bin_num = 5'(cf_qnum); num_data_pts = 16'(cf_npts);
    stream_mode = cf_stream; start = 1;
    @(negedge clk100);
    start = 0;
    i_min = $urandom; q_min = $urandom; i_bin_shift = 5'($urandom); q_bin_shift = 5'($urandom);
    i_bin_num = 5'($urandom); q_bin_num = 5'($urandom); num_data_pts = 16'($urandom);
    stream_mode = 1'($urandom);
    while (!ready && n < 400) begin @(negedge clk100); n++; end
    chk("clear_cycles", n, 257);
  endtask
  task automatic set_cfg(input int imin, input int qmin, input int ish, input int qsh,
                         input int inum, input int qnum, input int npts, input bit strm);
    cf_imin = imin; cf_qmin = qmin; cf_ish = ish; cf_qsh = qsh;
    cf_inum = inum; cf_qnum = qnum; cf_npts = npts; cf_stream = strm;
  endtask
  task automatic dump_check(input int mode, input int stop);
    int k = 0, cyc = 0, total, target;
    bit rd, stalled = 0;
    logic [10:0] cur, held = 0;
    total = cf_inum * cf_qnum;
    target = stop < total ? stop : total;
    while (k < target && cyc < 3000) begin
      rd = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      dump_ready = rd;
      cur = {dump_i, dump_q, dump_count, dump_last};
      if (stalled) chk("dump_hold", cur, held);
      stalled = dump_valid && !rd;
      held = cur;
      if (dump_valid && rd) begin
        chk("dump_word", cur, {4'(k / cf_qnum), 4'(k % cf_qnum),
            2'(tbl[k / cf_qnum][k % cf_qnum]), 1'(k == total - 1)});
        k++;
      end
      @(negedge clk100);
      cyc++;
    end
    dump_ready = 0;
    if (k < target) chk("dump_timeout", k, target);
    if (stop >= total) chk("done", {done, dump_valid}, 2'b10);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tv[0]  = '{-3, -3, 0, 0, 0, 0, 1};
    tv[1]  = '{-2, -2, 0, 0, 0, 0, 2};
    tv[2]  = '{-1, -1, 0, 0, 0, 0, 3};
    tv[3]  = '{ 0,  0, 1, 0, 0, 1, 3};
    tv[4]  = '{ 1,  1, 1, 1, 1, 1, 3};
    tv[5]  = '{-8,  7, 1, 0, 3, 1, 0};
    tv[6]  = '{32,  0, 0, 0, 0, 0, 1};
    tv[7]  = '{-9,  0, 0, 0, 0, 0, 2};
    tv[8]  = '{ 4,  7, 1, 4, 7, 1, 0};
    tv[9]  = '{ 4,  7, 1, 4, 7, 2, 0};
    tv[10] = '{ 4,  7, 1, 4, 7, 3, 0};
    tv[11] = '{ 2,  2, 1, 2, 2, 1, 0};
    tv[12] = '{ 2,  2, 1, 2, 2, 2, 0};
    tv[13] = '{ 2,  2, 1, 2, 2, 3, 0};
    tv[14] = '{ 2,  2, 1, 2, 2, 3, 0};
    tv[15] = '{ 2,  2, 1, 2, 2, 3, 0};
    tv[16] = '{ 4,  7, 1, 4, 7, 3, 0};
    do_reset;
    set_cfg(0, 0, 0, 0, 10, 10, 5, 0);
    do_start;
    run_vec(0, 4);
    dump_check(0, 1000);
    set_cfg(-8, -8, 2, 2, 10, 10, 3, 0);
    do_start;
    run_vec(5, 7);
    dump_check(1, 1000);
    for (int r = 0; r < 3; r++) begin
      set_cfg(int'($urandom_range(0, 40)) - 20, int'($urandom_range(0, 40)) - 20,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(1, 16)), int'($urandom_range(1, 16)), 40, 0);
      do_start;
      for (int s = 0; s < 40; s++)
        msend(cf_imin - 8 + int'($urandom_range(0, (cf_inum << cf_ish) + 16)),
              cf_qmin - 8 + int'($urandom_range(0, (cf_qnum << cf_qsh) + 16)));
      dump_check(2, 1000);
    end
    set_cfg(0, 0, 0, 0, 10, 10, 1, 1);
    do_start;
    run_vec(8, 10);
    start = 1;
    @(negedge clk100);
    start = 0;
    chk("start_ignored_in_accum", ready, 1);
    run_vec(11, 16);
    repeat (10) @(negedge clk100);
    chk("stream_no_dump", {dump_valid, done, ready}, 3'b001);
    do_reset;
    set_cfg(0, 0, 0, 0, 4, 4, 2, 0);
    do_start;
    msend(1, 1);
    msend(2, 3);
    dump_check(0, 3);
    do_reset;
    do_start;
    msend(-5, -5);
    msend(20, 0);
    dump_check(1, 1000);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
